if_fetch_unit: RTL and testbench



---
 rtl/misc_v_pkg.sv | 25 ++
 rtl/if_fetch_unit_if.sv | 42 ++++
 rtl/if_pc_reg.sv | 40 ++++
 rtl/if_fetch_unit.sv | 134 +++++++++++++
 tb/tb_if_fetch_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/misc_v_pkg.sv
// Shared types and constants for the 16-bit fetch stage.
// IF_SKID_BUF_EN adds the HOLD state used by the one-entry skid buffer.
package misc_v_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t NOP = 16'h0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1
`ifdef IF_SKID_BUF_EN
      ,
      HOLD = 2'd2
`endif
   } fetch_state_e;

   // Instructions are halfword aligned, so the low address bit is forced to zero.
   function automatic word_t align_pc(input word_t addr);
      return {addr[WORD_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, IF/ID and hazard logic.
// master is the fetch unit's view; slave is the surrounding pipeline's view.
interface if_fetch_unit_if;

   logic                Stall;
   logic                Redirect;
   misc_v_pkg::word_t   RedirectPC;
   logic                IMemReady;
   misc_v_pkg::word_t   IMemData;
   logic                IMemReq;
   misc_v_pkg::word_t   IMemAddr;
   misc_v_pkg::word_t   OPC;
   misc_v_pkg::word_t   OIR;
   logic                IFIDWrite;

   modport master (
      input  Stall,
      input  Redirect,
      input  RedirectPC,
      input  IMemReady,
      input  IMemData,
      output IMemReq,
      output IMemAddr,
      output OPC,
      output OIR,
      output IFIDWrite
   );

   modport slave (
      output Stall,
      output Redirect,
      output RedirectPC,
      output IMemReady,
      output IMemData,
      input  IMemReq,
      input  IMemAddr,
      input  OPC,
      input  OIR,
      input  IFIDWrite
   );

endinterface

// File: rtl/if_pc_reg.sv
// Program counter: async reset, sequential increment and aligned redirect load.
// A load always wins over an increment in the same cycle.
module if_pc_reg
   import misc_v_pkg::*;
#(
   parameter word_t RESET_PC = 16'h0000,
   parameter word_t PC_STEP  = 16'd2
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  inc_en,
   input  logic  load_en,
   input  word_t load_pc,
   output word_t pc
);

   word_t pc_q;
   word_t pc_d;

   // Wraparound past 16'hFFFE is intentional: plain modulo-2^16 addition.
   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = align_pc(load_pc);
      end else if (inc_en) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives instruction memory and loads the IF/ID register.
// Define IF_SKID_BUF_EN to keep a stalled fetch in a one-entry buffer instead of refetching it.
module if_fetch_unit
   import misc_v_pkg::*;
#(
   parameter word_t RESET_PC = 16'h0000,
   parameter word_t PC_STEP  = 16'd2
) (
   input logic             CLK,
   input logic             Reset,
   if_fetch_unit_if.master bus
);

   fetch_state_e state_q;
   fetch_state_e state_d;

   word_t pc;
   logic  pc_inc;
   logic  pc_load;

   logic  imem_req;
   logic  ifid_write;
   word_t opc;
   word_t oir;

`ifdef IF_SKID_BUF_EN
   word_t buf_pc_q;
   word_t buf_pc_d;
   word_t buf_ir_q;
   word_t buf_ir_d;
`endif

   if_pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk     (CLK),
      .rst     (Reset),
      .inc_en  (pc_inc),
      .load_en (pc_load),
      .load_pc (bus.RedirectPC),
      .pc      (pc)
   );

   // Outputs are combinational so IF/ID captures on the same edge that advances the PC.
   always_comb begin
      state_d    = state_q;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      imem_req   = 1'b0;
      ifid_write = 1'b0;
      opc        = 16'h0000;
      oir        = NOP;
`ifdef IF_SKID_BUF_EN
      buf_pc_d   = buf_pc_q;
      buf_ir_d   = buf_ir_q;
`endif

      case (state_q)
         IDLE: begin
            state_d = REQ;
         end

         REQ: begin
            imem_req = 1'b1;
            opc      = pc;
            if (bus.Stall) begin
`ifdef IF_SKID_BUF_EN
               if (bus.IMemReady) begin
                  buf_pc_d = pc;
                  buf_ir_d = bus.IMemData;
                  pc_inc   = 1'b1;
                  state_d  = HOLD;
               end
`endif
            end else begin
               ifid_write = 1'b1;
               if (bus.IMemReady) begin
                  oir    = bus.IMemData;
                  pc_inc = 1'b1;
               end
            end
         end

`ifdef IF_SKID_BUF_EN
         HOLD: begin
            opc = buf_pc_q;
            oir = buf_ir_q;
            if (!bus.Stall) begin
               ifid_write = 1'b1;
               state_d    = REQ;
            end
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase

      // A redirect squashes whatever is in flight; leaving HOLD also drops the buffer.
      if (bus.Redirect && (state_q != IDLE)) begin
         opc        = bus.RedirectPC;
         oir        = NOP;
         ifid_write = 1'b1;
         pc_inc     = 1'b0;
         pc_load    = 1'b1;
         state_d    = REQ;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
`ifdef IF_SKID_BUF_EN
         buf_pc_q <= 16'h0000;
         buf_ir_q <= NOP;
`endif
      end else begin
         state_q  <= state_d;
`ifdef IF_SKID_BUF_EN
         buf_pc_q <= buf_pc_d;
         buf_ir_q <= buf_ir_d;
`endif
      end
   end

   assign bus.IMemReq   = imem_req;
   assign bus.IMemAddr  = pc;
   assign bus.OPC       = opc;
   assign bus.OIR       = oir;
   assign bus.IFIDWrite = ifid_write;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vectors, literal checks and a cycle model.
// Honours IF_SKID_BUF_EN so the same bench covers both builds.
module tb_if_fetch_unit;

`ifdef IF_SKID_BUF_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic CLK;
   logic Reset;

   if_fetch_unit_if bus();

   if_fetch_unit #(
      .RESET_PC (16'h0000),
      .PC_STEP  (16'd2)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rpc,
                                input logic rdy, input logic [15:0] dat);
      @(posedge CLK);
      #1;
      bus.Stall      = st;
      bus.Redirect   = rd;
      bus.RedirectPC = rpc;
      bus.IMemReady  = rdy;
      bus.IMemData   = dat;
      @(negedge CLK);
      #1;
   endtask

   // Architectural model: has the stage started fetching, the PC, and an optional held fetch.
   logic        m_started, m_held;
   logic [15:0] m_pc, m_hpc, m_hir;
   logic        n_started, n_held;
   logic [15:0] n_pc, n_hpc, n_hir;

   always @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         m_started = 1'b0;
         m_held    = 1'b0;
         m_pc      = 16'h0000;
         m_hpc     = 16'h0000;
         m_hir     = 16'h0000;
      end else begin
         m_started = n_started;
         m_held    = n_held;
         m_pc      = n_pc;
         m_hpc     = n_hpc;
         m_hir     = n_hir;
      end
   end

   always @(negedge CLK) begin : compare
      logic        e_req, e_wr;
      logic [15:0] e_opc, e_oir;
      e_req     = 1'b0;
      e_wr      = 1'b0;
      e_opc     = 16'h0000;
      e_oir     = 16'h0000;
      n_started = 1'b1;
      n_held    = m_held;
      n_pc      = m_pc;
      n_hpc     = m_hpc;
      n_hir     = m_hir;
      if (Reset || !m_started) begin
         n_held = 1'b0;
      end else if (bus.Redirect) begin
         e_req  = !m_held;
         e_wr   = 1'b1;
         e_opc  = bus.RedirectPC;
         n_pc   = bus.RedirectPC & 16'hFFFE;
         n_held = 1'b0;
      end else if (m_held) begin
         e_wr  = !bus.Stall;
         e_opc = m_hpc;
         e_oir = m_hir;
         if (!bus.Stall) n_held = 1'b0;
      end else begin
         e_req = 1'b1;
         e_opc = m_pc;
         if (bus.Stall) begin
            if (SKID && bus.IMemReady) begin
               n_held = 1'b1;
               n_hpc  = m_pc;
               n_hir  = bus.IMemData;
               n_pc   = m_pc + 16'd2;
            end
         end else begin
            e_wr = 1'b1;
            if (bus.IMemReady) begin
               e_oir = bus.IMemData;
               n_pc  = m_pc + 16'd2;
            end
         end
      end
      checkOutput("mdl_IMemReq", {15'd0, bus.IMemReq}, {15'd0, e_req});
      checkOutput("mdl_IMemAddr", bus.IMemAddr, m_pc);
      checkOutput("mdl_IFIDWrite", {15'd0, bus.IFIDWrite}, {15'd0, e_wr});
      if (e_wr) begin
         checkOutput("mdl_OPC", bus.OPC, e_opc);
         checkOutput("mdl_OIR", bus.OIR, e_oir);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [15:0] vecStall;
   logic [15:0] vecRedir;
   logic [15:0] vecReady;

   initial begin
      Reset          = 1'b1;
      bus.Stall      = 1'b0;
      bus.Redirect   = 1'b0;
      bus.RedirectPC = 16'h0000;
      bus.IMemReady  = 1'b1;
      bus.IMemData   = 16'h1111;
      vecStall       = 16'b0011_0000_1100_0100;
      vecRedir       = 16'b0100_0010_0000_1000;
      vecReady       = 16'b1101_1011_0111_1011;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_IMemReq", {15'd0, bus.IMemReq}, 16'd0);
      checkOutput("rst_IFIDWrite", {15'd0, bus.IFIDWrite}, 16'd0);
      checkOutput("rst_OPC", bus.OPC, 16'h0000);
      checkOutput("rst_OIR", bus.OIR, 16'h0000);

      @(posedge CLK);
      #1;
      Reset = 1'b0;
      @(negedge CLK);
      #1;
      checkOutput("idle_IMemReq", {15'd0, bus.IMemReq}, 16'd0);

      $display("[TB] sequential fetch");
      applyStimulus(0, 0, 16'h0000, 1, 16'h1111);
      checkOutput("f0_IMemAddr", bus.IMemAddr, 16'h0000);
      checkOutput("f0_IFIDWrite", {15'd0, bus.IFIDWrite}, 16'd1);
      checkOutput("f0_OIR", bus.OIR, 16'h1111);
      applyStimulus(0, 0, 16'h0000, 1, 16'h1111);
      checkOutput("f1_IMemAddr", bus.IMemAddr, 16'h0002);

      $display("[TB] wait states");
      applyStimulus(0, 0, 16'h0000, 0, 16'h1111);
      checkOutput("ws0_OPC", bus.OPC, 16'h0004);
      checkOutput("ws0_OIR", bus.OIR, 16'h0000);
      applyStimulus(0, 0, 16'h0000, 0, 16'h1111);
      checkOutput("ws1_IMemAddr", bus.IMemAddr, 16'h0004);
      applyStimulus(0, 0, 16'h0000, 1, 16'h2222);
      checkOutput("ws2_OIR", bus.OIR, 16'h2222);
      checkOutput("ws2_OPC", bus.OPC, 16'h0004);

      $display("[TB] decode stall");
      applyStimulus(1, 0, 16'h0000, 1, 16'h3333);
      checkOutput("st0_IFIDWrite", {15'd0, bus.IFIDWrite}, 16'd0);
      checkOutput("st0_IMemAddr", bus.IMemAddr, 16'h0006);
      applyStimulus(1, 0, 16'h0000, 1, 16'h3333);
`ifdef IF_SKID_BUF_EN
      checkOutput("st1_IMemReq", {15'd0, bus.IMemReq}, 16'd0);
`else
      checkOutput("st1_IMemAddr", bus.IMemAddr, 16'h0006);
`endif
      applyStimulus(1, 0, 16'h0000, 1, 16'h3333);
      checkOutput("st2_IFIDWrite", {15'd0, bus.IFIDWrite}, 16'd0);
      applyStimulus(0, 0, 16'h0000, 1, 16'h3333);
      checkOutput("st3_OPC", bus.OPC, 16'h0006);
      checkOutput("st3_OIR", bus.OIR, 16'h3333);
      applyStimulus(0, 0, 16'h0000, 1, 16'h4444);
      checkOutput("st4_IMemAddr", bus.IMemAddr, 16'h0008);

      $display("[TB] redirect during stall");
      applyStimulus(1, 1, 16'h1235, 1, 16'h5555);
      checkOutput("rd0_IFIDWrite", {15'd0, bus.IFIDWrite}, 16'd1);
      checkOutput("rd0_OIR", bus.OIR, 16'h0000);
      checkOutput("rd0_OPC", bus.OPC, 16'h1235);
      applyStimulus(0, 0, 16'h0000, 1, 16'h5555);
      checkOutput("rd1_IMemAddr", bus.IMemAddr, 16'h1234);

      $display("[TB] PC wraparound");
      applyStimulus(0, 1, 16'hFFFE, 1, 16'h6666);
      applyStimulus(0, 0, 16'h0000, 1, 16'h6666);
      checkOutput("wr0_IMemAddr", bus.IMemAddr, 16'hFFFE);
      applyStimulus(0, 0, 16'h0000, 1, 16'h6666);
      checkOutput("wr1_IMemAddr", bus.IMemAddr, 16'h0000);

      $display("[TB] redirect after stalled fetch");
      applyStimulus(1, 0, 16'h0000, 1, 16'h7777);
      applyStimulus(1, 1, 16'h0100, 1, 16'h7777);
      checkOutput("rh0_OPC", bus.OPC, 16'h0100);
      checkOutput("rh0_OIR", bus.OIR, 16'h0000);
      applyStimulus(0, 0, 16'h0000, 1, 16'h8888);
      checkOutput("rh1_OIR", bus.OIR, 16'h8888);

      $display("[TB] reset mid-fetch");
      applyStimulus(0, 0, 16'h0000, 1, 16'h9999);
      checkOutput("rm0_IMemAddr", bus.IMemAddr, 16'h0102);
      Reset = 1'b1;
      #1;
      checkOutput("rm1_IFIDWrite", {15'd0, bus.IFIDWrite}, 16'd0);
      checkOutput("rm1_IMemReq", {15'd0, bus.IMemReq}, 16'd0);
      checkOutput("rm1_OIR", bus.OIR, 16'h0000);
      checkOutput("rm1_IMemAddr", bus.IMemAddr, 16'h0000);
      @(posedge CLK);
      #1;
      Reset        = 1'b0;
      bus.Redirect = 1'b1;
      bus.RedirectPC = 16'h4000;
      @(negedge CLK);
      #1;
      checkOutput("ri_IFIDWrite", {15'd0, bus.IFIDWrite}, 16'd0);
      applyStimulus(0, 0, 16'h0000, 1, 16'hAAAA);
      checkOutput("ri_IMemAddr", bus.IMemAddr, 16'h0000);

      $display("[TB] mixed vectors");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecStall[i], vecRedir[i], 16'h2001 + 16'(i * 16),
                       vecReady[i], 16'hA000 + 16'(i));
      end
      applyStimulus(0, 0, 16'h0000, 1, 16'hBBBB);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
